// File: rtl/cache_pkg.sv
// Shared constants and fill-state encoding for the L1I line-fill path.
// Geometry parameters derive tag width and beat counts from line/index sizes.
// Optional perf counters are enabled by defining LINE_FILL_PERF_EN.
package cache_pkg;
  localparam int offsetSize   = 5;
  localparam int indexSize    = 8;
  localparam int tagSize      = 64 - (offsetSize + indexSize);
  localparam int beatWidth    = 64;
  localparam int beatsPerLine = (8 * (2 ** offsetSize)) / beatWidth;
  localparam int beatIdxSize  = $clog2(beatsPerLine);

  typedef enum logic [2:0] {
    FILL_IDLE  = 3'd0,
    FILL_REQ   = 3'd1,
    FILL_DATA  = 3'd2,
    FILL_TAGWR = 3'd3,
    FILL_DRAIN = 3'd4
  } fill_state_t;
endpackage

// File: rtl/cache_line_fill_perf_counters.sv
// Completed-fill and aborted-fill event counters (LINE_FILL_PERF_EN builds only).
// Latency: count visible one cycle after the event strobe.
// No backpressure; counters wrap at 2^32.
`ifdef LINE_FILL_PERF_EN
module line_fill_perf_counters (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        fill_inc,
  input  logic        abort_inc,
  output logic [31:0] fill_count,
  output logic [31:0] abort_count
);

  // Free-running event counters, cleared only by reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fill_count  <= '0;
      abort_count <= '0;
    end else begin
      if (fill_inc)  fill_count  <= fill_count + 32'd1;
      if (abort_inc) abort_count <= abort_count + 32'd1;
    end
  end

endmodule
`endif

// File: rtl/cache_line_fill.sv
// L1I miss handler: one line read, beat writes into data array, then one tag write.
// Latency: memReq one cycle after miss accept; each beat written one cycle after arrival.
// Backpressure: miss_ready only in IDLE; memReq held until ready; beats cannot be stalled.
// Optional perf counters: LINE_FILL_PERF_EN.
module cache_line_fill
  import cache_pkg::*;
(
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   flushPipeline_i,
  input  logic                   miss_valid_i,
  input  logic [tagSize-1:0]     miss_tag_i,
  input  logic [indexSize-1:0]   miss_index_i,
  output logic                   miss_ready_o,
  input  logic                   fetchActive_i,
  output logic                   memReq_valid_o,
  output logic [63:0]            memReq_addr_o,
  input  logic                   memReq_ready_i,
  input  logic                   memResp_valid_i,
  input  logic [beatWidth-1:0]   memResp_data_i,
  output logic                   dataWrEnable_o,
  output logic [indexSize-1:0]   dataWrIndex_o,
  output logic [beatIdxSize-1:0] dataWrBeat_o,
  output logic [beatWidth-1:0]   dataWrData_o,
  output logic [tagSize-1:0]     newTag_o,
  output logic [indexSize-1:0]   newIndex_o,
  output logic                   updateEnable_o,
  output logic                   tagQueryStall_o,
  output logic [31:0]            fillCount_o,
  output logic [31:0]            abortCount_o
);

  fill_state_t            state, state_nxt;
  logic [tagSize-1:0]     tag_q;
  logic [indexSize-1:0]   index_q;
  logic [beatIdxSize-1:0] beat_cnt;
  logic                   last_beat;

  assign last_beat = (beat_cnt == beatIdxSize'(beatsPerLine - 1));

  // State register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= FILL_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; a flush coinciding with the final beat has nothing left to drain.
  always_comb begin
    state_nxt = state;
    case (state)
      FILL_IDLE:  if (miss_valid_i) state_nxt = FILL_REQ;
      FILL_REQ: begin
        if (memReq_ready_i)       state_nxt = flushPipeline_i ? FILL_DRAIN : FILL_DATA;
        else if (flushPipeline_i) state_nxt = FILL_IDLE;
      end
      FILL_DATA: begin
        if (flushPipeline_i)
          state_nxt = (memResp_valid_i && last_beat) ? FILL_IDLE : FILL_DRAIN;
        else if (memResp_valid_i && last_beat)
          state_nxt = FILL_TAGWR;
      end
      FILL_DRAIN: if (memResp_valid_i && last_beat) state_nxt = FILL_IDLE;
      FILL_TAGWR: if (!fetchActive_i) state_nxt = FILL_IDLE;
      default:    state_nxt = FILL_IDLE;
    endcase
  end

  // Capture the miss address and track beat position within the line.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      tag_q    <= '0;
      index_q  <= '0;
      beat_cnt <= '0;
    end else if (state == FILL_IDLE) begin
      if (miss_valid_i) begin
        tag_q    <= miss_tag_i;
        index_q  <= miss_index_i;
        beat_cnt <= '0;
      end
    end else if ((state == FILL_DATA || state == FILL_DRAIN) && memResp_valid_i) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Register each accepted beat into a data-array write on the following cycle.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      dataWrEnable_o <= 1'b0;
      dataWrIndex_o  <= '0;
      dataWrBeat_o   <= '0;
      dataWrData_o   <= '0;
    end else begin
      dataWrEnable_o <= (state == FILL_DATA) && memResp_valid_i && !flushPipeline_i;
      if ((state == FILL_DATA) && memResp_valid_i) begin
        dataWrIndex_o <= index_q;
        dataWrBeat_o  <= beat_cnt;
        dataWrData_o  <= memResp_data_i;
      end
    end
  end

  // miss_ready is masked by reset so every output reads 0 while reset is held.
  assign miss_ready_o    = (state == FILL_IDLE) && !reset_i;
  assign memReq_valid_o  = (state == FILL_REQ);
  assign memReq_addr_o   = {tag_q, index_q, {offsetSize{1'b0}}};
  assign tagQueryStall_o = (state != FILL_IDLE);
  assign updateEnable_o  = (state == FILL_TAGWR) && !fetchActive_i;
  // Tag memory ORs write addresses, so the index/tag must be zero when idle.
  assign newTag_o        = updateEnable_o ? tag_q   : '0;
  assign newIndex_o      = updateEnable_o ? index_q : '0;

`ifdef LINE_FILL_PERF_EN
  logic fill_done, drain_enter;
  assign fill_done   = updateEnable_o;
  assign drain_enter = flushPipeline_i &&
                       (((state == FILL_REQ) && memReq_ready_i) || (state == FILL_DATA));

  line_fill_perf_counters u_perf (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .fill_inc    (fill_done),
    .abort_inc   (drain_enter),
    .fill_count  (fillCount_o),
    .abort_count (abortCount_o)
  );
`else
  assign fillCount_o  = 32'd0;
  assign abortCount_o = 32'd0;
`endif

endmodule
